// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the input conditioner front end.
package input_conditioner_pkg;

  // Board and game timing defaults, kept next to the other game constants.
  localparam int unsigned DEF_CLK_HZ          = 32'd100_000_000;
  localparam int unsigned DEF_TICK_HZ         = 32'd60;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd1_000_000;

  // Debounced view of one button: steady level plus a one-cycle rise pulse.
  typedef struct packed {
    logic level;
    logic press;
  } btn_state_t;

  // Half period of game_clk in system clock cycles.
  function automatic int unsigned half_cycles(input int unsigned clk_hz,
                                              input int unsigned tick_hz);
    return clk_hz / (32'd2 * tick_hz);
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Button inputs and conditioned outputs between the board pins and game logic.
interface input_conditioner_if;
  logic btn_jump;
  logic btn_start;
  logic game_clk;
  logic jump;
  logic start;

  // Game-side view: drives raw buttons, consumes the slow clock and requests.
  modport master (
    output btn_jump, btn_start,
    input  game_clk, jump, start
  );

  // Conditioner view.
  modport slave (
    input  btn_jump, btn_start,
    output game_clk, jump, start
  );
endinterface

// File: rtl/input_conditioner_button_debouncer.sv
// Synchroniser, debouncer and rising-edge detector for one push-button.
module button_debouncer
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] D_MAX  = DW'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [DW-1:0] D_ZERO = DW'(0);
  localparam logic [DW-1:0] D_ONE  = DW'(1);

  logic          s1_r;
  logic          s2_r;
  logic          db_r;
  logic          db_d_r;
  logic [DW-1:0] dcnt_r;

  // Two-flop synchroniser, debounce counter and delayed copy for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r   <= 1'b0;
      s2_r   <= 1'b0;
      db_r   <= 1'b0;
      db_d_r <= 1'b0;
      dcnt_r <= D_ZERO;
    end else begin
      s1_r   <= raw;
      s2_r   <= s1_r;
      db_d_r <= db_r;
      if (s2_r == db_r) begin
        dcnt_r <= D_ZERO;
      end else if (dcnt_r == D_MAX) begin
        db_r   <= s2_r;
        dcnt_r <= D_ZERO;
      end else begin
        dcnt_r <= dcnt_r + D_ONE;
      end
    end
  end

  assign level = db_r;
  assign press = db_r & ~db_d_r;

endmodule

// File: rtl/input_conditioner.sv
// Derives game_clk and holds button requests stable across each game tick.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned CLK_HZ          = DEF_CLK_HZ,
  parameter int unsigned TICK_HZ         = DEF_TICK_HZ,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input_conditioner_if.slave   bus
);

  localparam int unsigned HALF = half_cycles(CLK_HZ, TICK_HZ);
  localparam int unsigned TW   = cnt_width(HALF);
  localparam logic [TW-1:0] T_MAX  = TW'(HALF - 32'd1);
  localparam logic [TW-1:0] T_ZERO = TW'(0);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  btn_state_t    jump_btn_s;
  btn_state_t    start_btn_s;

  logic [TW-1:0] tcnt_r;
  logic          game_clk_r;
  logic          pend_j_r;
  logic          pend_s_r;
  logic          jump_r;
  logic          start_r;

  logic          fall_s;
  logic          pend_j_nxt_s;
  logic          pend_s_nxt_s;
  logic          jump_nxt_s;
  logic          start_nxt_s;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_jump_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.btn_jump),
    .level (jump_btn_s.level),
    .press (jump_btn_s.press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.btn_start),
    .level (start_btn_s.level),
    .press (start_btn_s.press)
  );

  // The output update happens in the cycle where game_clk is about to fall.
  assign fall_s = game_clk_r & (tcnt_r == T_MAX);

  // Half-period counter that toggles game_clk on wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_r     <= T_ZERO;
      game_clk_r <= 1'b0;
    end else if (tcnt_r == T_MAX) begin
      tcnt_r     <= T_ZERO;
      game_clk_r <= ~game_clk_r;
    end else begin
      tcnt_r     <= tcnt_r + T_ONE;
    end
  end

  // Latch presses until the next fall; a press landing on the fall itself is used directly.
  always_comb begin
    jump_nxt_s   = jump_r;
    start_nxt_s  = start_r;
    pend_j_nxt_s = pend_j_r;
    pend_s_nxt_s = pend_s_r;
    if (fall_s) begin
      jump_nxt_s   = pend_j_r | jump_btn_s.press | jump_btn_s.level;
      start_nxt_s  = pend_s_r | start_btn_s.press | start_btn_s.level;
      pend_j_nxt_s = 1'b0;
      pend_s_nxt_s = 1'b0;
    end else begin
      pend_j_nxt_s = pend_j_r | jump_btn_s.press;
      pend_s_nxt_s = pend_s_r | start_btn_s.press;
    end
  end

  // Pending flags and output registers; a reset drops any press still waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_j_r <= 1'b0;
      pend_s_r <= 1'b0;
      jump_r   <= 1'b0;
      start_r  <= 1'b0;
    end else begin
      pend_j_r <= pend_j_nxt_s;
      pend_s_r <= pend_s_nxt_s;
      jump_r   <= jump_nxt_s;
      start_r  <= start_nxt_s;
    end
  end

  assign bus.game_clk = game_clk_r;
  assign bus.jump     = jump_r;
  assign bus.start    = start_r;

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end stage feeding the game-logic block. From the board system clock it derives the slow `game_clk` (about 60 Hz) that the game logic runs on. It also synchronises and debounces the raw `jump` and `start` push-buttons. It then presents `jump`/`start` as levels that are stable around every `game_clk` rising edge, so a short press between two game ticks is never lost.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: system clock frequency.
- `TICK_HZ`, 60: `game_clk` frequency. `HALF = CLK_HZ/(2*TICK_HZ)`, integer division, must be ≥ 2.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive `clk` cycles a synchronised input must differ from its debounced value before the debounced value flips. Must be ≥ 1.

Ports:
- `clk`, in, 1: system clock. One clock domain only.
- `rst`, in, 1: synchronous, active-high reset.
- `btn_jump`, in, 1: raw jump button, asynchronous, active high.
- `btn_start`, in, 1: raw start button, asynchronous, active high.
- `game_clk`, out, 1: registered square wave, 50 % duty, period `2*HALF` clk cycles.
- `jump`, out, 1: conditioned jump request, changes only on `game_clk` falling edges.
- `start`, out, 1: conditioned start request, changes only on `game_clk` falling edges.

## Operation
- **Reset** (`rst`=1 at a `clk` edge): `game_clk`=0, `jump`=0, `start`=0. Also clears all synchroniser flops, debounce counters, debounced values, edge-detect flops, pending flags and the tick counter. Reset mid-operation discards any pending press.
- **Tick generator**:
  - `tcnt` counts 0..HALF-1.
  - At `tcnt==HALF-1`: `tcnt`←0 and `game_clk` toggles. Otherwise `tcnt`←`tcnt`+1.
  - Width is `$clog2(HALF)` bits.
- **Per button** (identical for jump and start):
  - 2-flop synchroniser `s1`→`s2`.
  - Debouncer on `s2`. If `s2`==`db`, `dcnt`←0. Otherwise, if `dcnt`==DEBOUNCE_CYCLES-1 then `db`←`s2` and `dcnt`←0, else `dcnt`←`dcnt`+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes `db`.
  - Rising-edge detect: `press` = `db` & ~`db_d`, a one-cycle pulse.
  - `pend` is set by `press` and cleared at output update.
- **Output update**: occurs in the `clk` cycle where `game_clk` toggles 1→0. There, `jump` ← `pend_j` | `press_j` | `db_j`, and `pend_j`←0. `start` uses the same rule.
- **Simultaneous events**:
  - A press in the same cycle as the update is included in this update, and `pend` stays 0.
  - A press in any other cycle waits for the next falling edge.
- **Held button**: the output stays 1 for as long as `db` is 1. Game logic treats jump as level-sensitive.

## Timing
- Raw input to `db`: a clean raw edge changes `db` after 2 (synchroniser) + DEBOUNCE_CYCLES `clk` edges.
- `press`: asserted the cycle after `db` rises.
- Output latency: between 0 and `2*HALF` cycles after `press`, at the next `game_clk` fall. That is at least HALF cycles of setup before the following `game_clk` rise.
- Output hold: `jump`/`start` are constant for the full `2*HALF` cycles between updates, so they are always stable at `game_clk` rising edges.
- Short press: a press shorter than one game tick, but at least DEBOUNCE_CYCLES long, produces exactly one game tick with output 1.
- Reset release: the first `game_clk` rise comes HALF cycles after `rst` deasserts.

## Structure
- Add `CLK_HZ`, `TICK_HZ` and `DEBOUNCE_CYCLES` defaults to the shared `parameters.v`, next to the screen and game constants.
- Sub-module `button_debouncer` (params `DEBOUNCE_CYCLES`; ports `clk`, `rst`, `raw`, `level`, `press`) contains the synchroniser, debouncer and edge detect. It is instantiated twice.
- The top level holds the tick generator, the pending flags and the output registers.

## Test plan
All scenarios use `CLK_HZ=1200`, `TICK_HZ=60` (HALF=10) and `DEBOUNCE_CYCLES=4`.
1. Reset for 3 cycles, then idle → outputs 0. `game_clk` rises at cycle 10 after reset release and falls at cycle 20, with period 20 thereafter.
2. Raw `btn_jump` high for 3 cycles, then low → `db` never rises, and `jump` stays 0 across 5 ticks.
3. `btn_jump` high for 6 cycles starting 2 cycles after a `game_clk` fall → `jump`=1 from the next fall for exactly one 20-cycle tick, then 0.
4. `btn_start` held high for 100 cycles → `start`=1 on every update while `db` is 1. It drops to 0 at the first fall after `db` returns to 0, which is 6 cycles after release.
5. Press timed so that `press_j` coincides with the falling-edge update cycle → `jump`=1 in that same update, and `pend_j` is 0 afterwards with no extra tick.
6. `jump` press pending, `rst` pulsed before the next fall → `jump` stays 0 and no delayed pulse appears after reset.
